// File: rtl/if_id_queue.sv
// IF->ID elastic queue: DEPTH-entry FIFO of {pc, inst} with MIPS field split at the head.
// Optional stall/flush statistics counters are enabled by defining IF_ID_QUEUE_STAT_EN.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              imm_sext,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_sa,
  output logic [5:0]        id_fn,
  output logic [31:0]       id_imm,
  output logic [25:0]       id_target,
  output logic [PTR_W:0]    count
`ifdef IF_ID_QUEUE_STAT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] head_inst;

  // Ready depends only on occupancy, so decode backpressure never reaches fetch combinationally.
  assign if_ready = (count != FULL);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush;
  assign pop      = id_valid & id_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  // Gate the head with id_valid so stale or uninitialised storage never leaks out.
  assign head_inst = id_valid ? inst_mem[rd_ptr] : '0;
  assign id_pc     = id_valid ? pc_mem[rd_ptr]   : '0;

  assign id_opcode = head_inst[31:26];
  assign id_rs     = head_inst[25:21];
  assign id_rt     = head_inst[20:16];
  assign id_rd     = head_inst[15:11];
  assign id_sa     = head_inst[10:6];
  assign id_fn     = head_inst[5:0];
  assign id_target = head_inst[25:0];
  assign id_imm    = {{16{imm_sext & head_inst[15]}}, head_inst[15:0]};

`ifdef IF_ID_QUEUE_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_valid && !if_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model plus directed and random traffic.
// Statistics outputs are checked when IF_ID_QUEUE_STAT_EN is defined.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst;
  logic             imm_sext;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [4:0]       id_sa;
  logic [5:0]       id_fn;
  logic [31:0]      id_imm;
  logic [25:0]      id_target;
  logic [PTR_W:0]   count;
`ifdef IF_ID_QUEUE_STAT_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .imm_sext(imm_sext), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_sa(id_sa), .id_fn(id_fn), .id_imm(id_imm), .id_target(id_target),
    .count(count)
`ifdef IF_ID_QUEUE_STAT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of {pc, inst} entries plus event counters.
  logic [63:0] mq [$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (if_valid && mq.size() == DEPTH) m_stall++;
      if (flush) m_flush++;
      if (flush) begin
        mq.delete();
      end else begin
        m_push = if_valid && (mq.size() != DEPTH);
        m_pop  = id_ready && (mq.size() != 0);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back({if_pc, if_inst});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Log of pcs actually handed to decode, and the peak occupancy seen.
  logic [31:0] popped [$];
  int          max_cnt = 0;

  always begin
    logic [63:0]        head;
    logic [31:0]        inst;
    logic signed [31:0] simm;
    logic [31:0]        exp_imm;
    bit                 ev;
    @(negedge clk);
    #4;
    ev   = (mq.size() != 0);
    head = ev ? mq[0] : 64'd0;
    inst = head[31:0];
    simm = $signed(inst[15:0]);
    exp_imm = imm_sext ? simm : {16'd0, inst[15:0]};
    checkOutput("id_valid",  32'(id_valid),  32'(ev));
    checkOutput("if_ready",  32'(if_ready),  32'(mq.size() != DEPTH));
    checkOutput("count",     32'(count),     32'(mq.size()));
    checkOutput("id_pc",     id_pc,          head[63:32]);
    checkOutput("id_opcode", 32'(id_opcode), 32'(inst / 32'h0400_0000));
    checkOutput("id_rs",     32'(id_rs),     (inst >> 21) % 32);
    checkOutput("id_rt",     32'(id_rt),     (inst >> 16) % 32);
    checkOutput("id_rd",     32'(id_rd),     (inst >> 11) % 32);
    checkOutput("id_sa",     32'(id_sa),     (inst >> 6) % 32);
    checkOutput("id_fn",     32'(id_fn),     inst % 64);
    checkOutput("id_imm",    id_imm,         exp_imm);
    checkOutput("id_target", 32'(id_target), inst % 32'h0400_0000);
`ifdef IF_ID_QUEUE_STAT_EN
    checkOutput("stall_cnt", stall_cnt, m_stall);
    checkOutput("flush_cnt", flush_cnt, m_flush);
`endif
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (rst_n && id_valid && id_ready && !flush) popped.push_back(id_pc);
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic rdy, input logic sx, input logic fl);
    @(negedge clk);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    imm_sext = sx;
    flush    = fl;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_seq [$];
    logic [31:0] pushed [$];
    logic [31:0] next_pc;
    logic        v;

    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    imm_sext = 1'b0; id_ready = 1'b0;

    // Test 1: reset, then stream three instructions with decode always ready.
    idle(1, 1'b1);
    #4 checkOutput("reset_id_valid", 32'(id_valid), 32'd0);
    idle(2, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    popped.delete();
    max_cnt = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    checkOutput("stream_len", 32'(popped.size()), 32'd3);
    exp_seq = '{32'h00, 32'h04, 32'h08};
    for (int i = 0; i < 3 && i < popped.size(); i++) checkOutput("stream_pc", popped[i], exp_seq[i]);
    checkOutput("stream_maxcount", 32'(max_cnt), 32'd1);

    // Test 2: backpressure fill, one fetch held upstream, then release.
    popped.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h10 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, $urandom, 1'b0, 1'b0, 1'b0);
    #4;
    checkOutput("full_if_ready", 32'(if_ready), 32'd0);
    checkOutput("full_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    exp_seq = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    checkOutput("bp_len", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++) checkOutput("bp_order", popped[i], exp_seq[i]);

    // Test 3: field split of lw with both immediate extension modes.
    applyStimulus(1'b1, 32'h100, 32'h8C8A_FFF0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    #4;
    checkOutput("lw_opcode", 32'(id_opcode), 32'h23);
    checkOutput("lw_rs", 32'(id_rs), 32'd4);
    checkOutput("lw_rt", 32'(id_rt), 32'd10);
    checkOutput("lw_imm_sext", id_imm, 32'hFFFF_FFF0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #4 checkOutput("lw_imm_zext", id_imm, 32'h0000_FFF0);
    idle(2, 1'b1);

    // Test 4: flush while full-ish and while a fetch is presented.
    applyStimulus(1'b1, 32'h40, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h44, $urandom, 1'b0, 1'b0, 1'b0);
    popped.delete();
    applyStimulus(1'b1, 32'h99, $urandom, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    #4;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_id_valid", 32'(id_valid), 32'd0);
    idle(3, 1'b1);
    checkOutput("flush_nothing_out", 32'(popped.size()), 32'd0);

    // Test 5: random traffic across several pointer wraps.
    popped.delete();
    pushed.delete();
    next_pc = 32'h1000;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, next_pc, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      #4;
      if (v && mq.size() != DEPTH) begin
        pushed.push_back(next_pc);
        next_pc += 32'd4;
      end
    end
    idle(DEPTH + 2, 1'b1);
    checkOutput("wrap_len", 32'(popped.size()), 32'(pushed.size()));
    for (int i = 0; i < pushed.size() && i < popped.size(); i++)
      checkOutput("wrap_order", popped[i], pushed[i]);

    // Test 6: asynchronous reset between clock edges with three entries held.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h200 + 32'(i * 4), 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("pre_reset_count", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 32'd0);
    checkOutput("async_id_valid", 32'(id_valid), 32'd0);
    checkOutput("async_id_pc", id_pc, 32'd0);
    checkOutput("async_id_imm", id_imm, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h310, $urandom, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #4;
    checkOutput("post_flush_count", 32'(count), 32'd0);
`ifdef IF_ID_QUEUE_STAT_EN
    checkOutput("stall_cnt_five", stall_cnt, 32'd5);
    checkOutput("flush_cnt_one", flush_cnt, 32'd1);
`endif
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
